// File: rtl/zx_keyboard_matrix_sync.sv
// ZX BUS keyboard port, clocked and parametrised.
// Takes CH446Q-style serial key commands from the HIDman MCU. Each frame
// holds ADDR_BITS address bits, AY first and MSB first. The frame is
// committed by an STB rise, and the key state is taken from DAT at that
// moment. The block keeps a ROWS x COLS key matrix plus the PAUSE, MAGIC and
// RESET special keys. Z80 reads of port #FE return the AND of the half-rows
// selected by the A[15:8] bits that are low.
// Optional feature: define KEYMATRIX_WDT_EN to build the MCU-heartbeat
// watchdog. When it times out, every key and special key is released.
module zx_keyboard_matrix_sync #(
  parameter int ROWS     = 8,
  parameter int COLS     = 5,
  parameter int AX_BITS  = 4,
  parameter int AY_BITS  = 3,
  parameter int WDT_CLKS = 1750000
) (
  input  logic            clk,
  input  logic            rst_in,
  input  logic            DAT,
  input  logic            SK,
  input  logic            STB,
  input  logic [15:0]     A,
  input  logic            M1,
  input  logic            RD,
  input  logic            IORQ,
  output logic [COLS-1:0] D,
  output logic            IORQGE,
  output logic            enable,
  output logic            PAUSE,
  output logic            MAGIC,
  output logic            RESET,
  output logic            frame_err,
  output logic            wdt_expired
);

  localparam int ADDR_BITS = AX_BITS + AY_BITS;
  localparam int CNT_W     = $clog2(ADDR_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ADDR_BITS);

  // Bit order in these vectors is {STB, SK, DAT}.
  logic [2:0] meta_q, sync_q, hist_q;
  logic       dat_s, sk_rise, stb_rise;

  logic [ADDR_BITS-1:0]       shreg_q;
  logic [CNT_W-1:0]           bit_cnt_q;
  logic                       new_frame_q;
  logic [ROWS-1:0][COLS-1:0]  keys_q;

  logic [AX_BITS-1:0] ax;
  logic [AY_BITS-1:0] ay;
  logic               commit;
  logic               wdt_fire;

  // Two-flop synchroniser plus one history flop per MCU line.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      meta_q <= '0;
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      // NOTE: every clocked block uses <=, so all flops sample the old values
      // together and the order of statements inside the block does not matter.
      meta_q <= {STB, SK, DAT};
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign dat_s    = sync_q[0];
  assign sk_rise  = sync_q[1] & ~hist_q[1];
  assign stb_rise = sync_q[2] & ~hist_q[2];

  // DAT is sampled by level and never edge-detected, so its history flop
  // has no reader.
  logic unused_ok;
  assign unused_ok = &{1'b0, hist_q[0], A[7:1]};

  assign ax     = shreg_q[AX_BITS-1:0];
  assign ay     = shreg_q[ADDR_BITS-1:AX_BITS];
  assign commit = stb_rise && (bit_cnt_q == CNT_FULL);

  // Shift register and bit counter. STB takes priority over a coincident SK
  // rise, which is dropped and reported as a frame error.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      new_frame_q <= 1'b0;
      frame_err   <= 1'b0;
    end else if (stb_rise) begin
      new_frame_q <= 1'b1;
      frame_err   <= (bit_cnt_q != CNT_FULL) | sk_rise;
    end else begin
      frame_err <= 1'b0;
      if (sk_rise) begin
        shreg_q     <= {shreg_q[ADDR_BITS-2:0], dat_s};
        new_frame_q <= 1'b0;
        if (new_frame_q)                bit_cnt_q <= CNT_W'(1);
        else if (bit_cnt_q != CNT_FULL) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
    end
  end

  // Key matrix and special keys. A commit takes priority over a watchdog
  // release in the same cycle.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      // NOTE: keys_q is a small register bank and not a RAM, so it gets the
      // asynchronous reset and powers up with every key released.
      keys_q <= '1;
      PAUSE  <= 1'b0;
      MAGIC  <= 1'b0;
      RESET  <= 1'b0;
    end else if (commit) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (int'(ax) == r && int'(ay) == c) keys_q[r][c] <= ~dat_s;
      if (int'(ax) == 8) begin
        case (int'(ay))
          4:       if (dat_s) keys_q <= '1;
          5:       MAGIC <= dat_s;
          6:       RESET <= dat_s;
          7:       PAUSE <= dat_s;
          default: ;
        endcase
      end
    end else if (wdt_fire) begin
      keys_q <= '1;
      PAUSE  <= 1'b0;
      MAGIC  <= 1'b0;
      RESET  <= 1'b0;
    end
  end

`ifdef KEYMATRIX_WDT_EN
  localparam int WDT_W = $clog2(WDT_CLKS + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CLKS - 1);
  logic [WDT_W-1:0] wdt_cnt_q;

  assign wdt_fire = (wdt_cnt_q == WDT_LAST);

  // Heartbeat watchdog. Any accepted frame restarts it. Once it reaches the
  // last count it stays there until the next accepted frame.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      wdt_cnt_q   <= '0;
      wdt_expired <= 1'b0;
    end else if (commit) begin
      wdt_cnt_q   <= '0;
      wdt_expired <= 1'b0;
    end else if (wdt_cnt_q != WDT_LAST) begin
      wdt_cnt_q <= wdt_cnt_q + WDT_W'(1);
    end else begin
      wdt_expired <= 1'b1;
    end
  end
`else
  assign wdt_fire    = 1'b0;
  assign wdt_expired = 1'b0;
`endif

  // Port #FE read: AND together every half-row whose address line is low.
  always_comb begin
    // NOTE: D gets its default before the loop so every path assigns it and
    // no latch is inferred.
    D = '1;
    for (int r = 0; r < ROWS; r++)
      if (!A[8+r]) D = D & keys_q[r];
  end

  // I/O decode for an even-port access outside an interrupt acknowledge.
  assign IORQGE = ~(~A[0] & M1);
  assign enable = ~A[0] & M1 & ~RD & ~IORQ;

endmodule

// File: tb/tb_zx_keyboard_matrix_sync.sv
// Self-checking bench for zx_keyboard_matrix_sync (ROWS=8, COLS=5).
module tb_zx_keyboard_matrix_sync;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        DAT, SK, STB;
  logic [15:0] A;
  logic        M1, RD, IORQ;
  logic [4:0]  D;
  logic        IORQGE, enable, PAUSE, MAGIC, RESET, frame_err, wdt_expired;

  int tests_run    = 0;
  int tests_failed = 0;
  int err_pulses   = 0;
  int e0;

  zx_keyboard_matrix_sync #(
    .ROWS(8), .COLS(5), .AX_BITS(4), .AY_BITS(3), .WDT_CLKS(100)
  ) dut (
    .clk(clk), .rst_in(rst_in), .DAT(DAT), .SK(SK), .STB(STB),
    .A(A), .M1(M1), .RD(RD), .IORQ(IORQ),
    .D(D), .IORQGE(IORQGE), .enable(enable),
    .PAUSE(PAUSE), .MAGIC(MAGIC), .RESET(RESET),
    .frame_err(frame_err), .wdt_expired(wdt_expired)
  );

  always #5 clk = ~clk;

  // Count the clock cycles in which frame_err is high.
  always @(posedge clk) if (frame_err) err_pulses++;

  typedef struct {
    string       name;
    logic [15:0] a;
    logic        m1, rd, iorq;
    logic [4:0]  d;
    logic        ge, en;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic read_bus(input logic [15:0] a);
    A = a; M1 = 1'b1; RD = 1'b0; IORQ = 1'b0;
    #1;
  endtask

  task automatic send_bit(input logic b);
    DAT = b; wait_clk(3);
    SK = 1'b1; wait_clk(3);
    SK = 1'b0; wait_clk(3);
  endtask

  // A frame is {AY, AX}, sent MSB first.
  task automatic send_addr(input logic [3:0] ax, input logic [2:0] ay);
    logic [6:0] f;
    f = {ay, ax};
    for (int i = 6; i >= 0; i--) send_bit(f[i]);
  endtask

  task automatic strobe(input logic ks);
    DAT = ks; wait_clk(3);
    STB = 1'b1; wait_clk(3);
    STB = 1'b0; wait_clk(3);
  endtask

  task automatic press(input logic [3:0] ax, input logic [2:0] ay);
    send_addr(ax, ay);
    strobe(1'b1);
  endtask

  initial begin
    rst_in = 1'b1; DAT = 1'b0; SK = 1'b0; STB = 1'b0;
    A = 16'hFEFE; M1 = 1'b1; RD = 1'b0; IORQ = 1'b0;

    vecs[0]  = '{"rd_row0",    16'hFEFE, 1'b1, 1'b0, 1'b0, 5'b11110, 1'b0, 1'b1};
    vecs[1]  = '{"rd_row3",    16'hF7FE, 1'b1, 1'b0, 1'b0, 5'b11011, 1'b0, 1'b1};
    vecs[2]  = '{"rd_row7",    16'h7FFE, 1'b1, 1'b0, 1'b0, 5'b01111, 1'b0, 1'b1};
    vecs[3]  = '{"rd_r037",    16'h76FE, 1'b1, 1'b0, 1'b0, 5'b01010, 1'b0, 1'b1};
    vecs[4]  = '{"rd_all",     16'h00FE, 1'b1, 1'b0, 1'b0, 5'b01010, 1'b0, 1'b1};
    vecs[5]  = '{"rd_none",    16'hFFFE, 1'b1, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b1};
    vecs[6]  = '{"rd_row1",    16'hFDFE, 1'b1, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b1};
    vecs[7]  = '{"rd_odd",     16'hFEFF, 1'b1, 1'b0, 1'b0, 5'b11110, 1'b1, 1'b0};
    vecs[8]  = '{"rd_m1low",   16'hFEFE, 1'b0, 1'b0, 1'b0, 5'b11110, 1'b1, 1'b0};
    vecs[9]  = '{"rd_rdhigh",  16'hFEFE, 1'b1, 1'b1, 1'b0, 5'b11110, 1'b0, 1'b0};
    vecs[10] = '{"rd_iorqhi",  16'hFEFE, 1'b1, 1'b0, 1'b1, 5'b11110, 1'b0, 1'b0};

    wait_clk(4);
    rst_in = 1'b0;
    wait_clk(2);

    // Reset state
    read_bus(16'hFEFE);
    check("rst_D", D, 5'b11111);
    check("rst_enable", enable, 1'b1);
    check("rst_specials", {PAUSE, MAGIC, RESET}, 3'b000);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_wdt", wdt_expired, 1'b0);

    // Caps Shift press, then release with exact latency
    press(4'd0, 3'd0);
    read_bus(16'hFEFE); check("cs_press", D, 5'b11110);
    read_bus(16'h7FFE); check("cs_other_row", D, 5'b11111);
    read_bus(16'hFEFE);
    DAT = 1'b0; wait_clk(3);
    STB = 1'b1;
    wait_clk(1); check("cs_rel_n", D, 5'b11110);
    wait_clk(1); check("cs_rel_n1", D, 5'b11110);
    wait_clk(1); check("cs_rel_n2", D, 5'b11111);
    wait_clk(2); STB = 1'b0; wait_clk(3);

    // A repeated STB on the same address is still a valid commit
    strobe(1'b1);
    check("restrobe", D, 5'b11110);

    // Short frame: 5 zeros would address CS if wrongly accepted
    e0 = err_pulses;
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    strobe(1'b0);
    check("short_err", err_pulses - e0, 1);
    check("short_D", D, 5'b11110);

    // Special keys
    e0 = err_pulses;
    press(4'd8, 3'd6);
    check("reset_on", {PAUSE, MAGIC, RESET}, 3'b001);
    check("good_no_err", err_pulses - e0, 0);
    strobe(1'b0);
    check("reset_off", RESET, 1'b0);
    press(4'd8, 3'd5);
    check("magic_on", {PAUSE, MAGIC, RESET}, 3'b010);
    press(4'd8, 3'd7);
    check("pause_on", {PAUSE, MAGIC, RESET}, 3'b110);
    send_addr(4'd8, 3'd5); strobe(1'b0);
    check("magic_off", {PAUSE, MAGIC, RESET}, 3'b100);

    // Q and P, then release-all
    press(4'd2, 3'd0);
    press(4'd5, 3'd0);
    read_bus(16'h00FE); check("qp_all", D, 5'b11110);
    read_bus(16'hDFFE); check("p_row5", D, 5'b11110);
    read_bus(16'h00FE);
    send_addr(4'd8, 3'd4); strobe(1'b0);
    check("relall_dat0", D, 5'b11110);
    strobe(1'b1);
    check("relall", D, 5'b11111);
    check("relall_pause_kept", PAUSE, 1'b1);

    // SK and STB rising together: STB commits (1,0), SK is dropped
    send_addr(4'd1, 3'd0);
    e0 = err_pulses;
    DAT = 1'b1; wait_clk(3);
    SK = 1'b1; STB = 1'b1; wait_clk(3);
    SK = 1'b0; STB = 1'b0; wait_clk(3);
    read_bus(16'hFDFE);
    check("simul_err", err_pulses - e0, 1);
    check("simul_commit", D, 5'b11110);
    e0 = err_pulses;
    strobe(1'b0);
    check("simul_shreg_kept", D, 5'b11111);
    check("simul_after_err", err_pulses - e0, 0);

    // Read-path table
    press(4'd0, 3'd0);
    press(4'd3, 3'd2);
    press(4'd7, 3'd4);
    foreach (vecs[i]) begin
      A = vecs[i].a; M1 = vecs[i].m1; RD = vecs[i].rd; IORQ = vecs[i].iorq;
      #1;
      check({vecs[i].name, "_D"}, D, vecs[i].d);
      check({vecs[i].name, "_ge"}, IORQGE, vecs[i].ge);
      check({vecs[i].name, "_en"}, enable, vecs[i].en);
    end
    read_bus(16'hFEFE);

    // Reset mid-frame, then a fresh frame
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    rst_in = 1'b1; wait_clk(2); rst_in = 1'b0; wait_clk(2);
    read_bus(16'h00FE);
    check("midrst_D", D, 5'b11111);
    check("midrst_pause", PAUSE, 1'b0);
    press(4'd4, 3'd1);
    read_bus(16'hEFFE);
    check("fresh_frame", D, 5'b11101);

    // Watchdog
    press(4'd6, 3'd3);
    read_bus(16'hBFFE);
    wait_clk(50);
    check("wdt_early", D, 5'b10111);
    wait_clk(100);
`ifdef KEYMATRIX_WDT_EN
    check("wdt_release", D, 5'b11111);
    check("wdt_flag", wdt_expired, 1'b1);
    press(4'd8, 3'd3);
    check("wdt_heartbeat", wdt_expired, 1'b0);
`else
    check("nowdt_persist", D, 5'b10111);
    check("nowdt_flag", wdt_expired, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/zx_keyboard_matrix_sync.md
# zx_keyboard_matrix_sync

Clocked, parametrised successor to the ZX BUS keyboard port. It receives CH446Q-style serial key commands from the HIDman MCU, synchronises them into the bus clock domain, and holds a ROWS×COLS key matrix plus three special-key outputs. It answers Z80 reads of port #FE with the half-row AND of the selected matrix rows. It adds a frame-length check, a release-all command, and an optional MCU-heartbeat watchdog.

## Interface
- ROWS, 8, matrix half-rows, selected by A[8+r] low; 1..8
- COLS, 5, data bits per half-row, driven on D[COLS-1:0]; 1..8
- AX_BITS, 4, serial X-field width; AX values ≥ ROWS are command space
- AY_BITS, 3, serial Y-field width; AY must cover COLS-1 and 7
- WDT_CLKS, 1750000, watchdog timeout in clk cycles (0.5 s at 3.5 MHz)
- clk  in  1  ZX BUS CLK; all state on rising edge
- rst_in  in  1  asynchronous, active-high reset
- DAT, SK, STB  in  1 each  asynchronous MCU serial lines
- A  in  16  Z80 address
- M1, RD, IORQ  in  1 each  Z80 strobes; RD and IORQ active low
- D  out  COLS  half-row state, 1 = released
- IORQGE  out  1  0 when A[0]=0 and M1=1, else 1
- enable  out  1  1 when the IORQGE condition holds and RD=0 and IORQ=0
- PAUSE, MAGIC, RESET  out  1 each  1 = asserted (drives FET gate)
- frame_err  out  1  one-clk pulse on a rejected frame
- wdt_expired  out  1  sticky watchdog flag; tied 0 when the watchdog is compiled out

## Operation
- Sync: each of DAT, SK, STB passes through 2 flops plus 1 history flop. Edge rise = sync & ~history.
- Shift: on SK rise, shift the synced DAT into an ADDR_BITS = AX_BITS+AY_BITS shift register, LSB in. The field layout is {AY, AX}: AY first, MSB first.
- Bit counter saturates at ADDR_BITS. The first SK rise after any STB rise clears it to 1, starting a new frame.
- STB rise with count < ADDR_BITS: no state change, frame_err pulse.
- STB rise with count = ADDR_BITS: commit using key_state = synced DAT. Multiple STBs for one address are all valid.
- Commit rules:
  - AX < ROWS and AY < COLS: keys[AX][AY] = ~key_state.
  - AX = 8, AY = 3: heartbeat; no state change.
  - AX = 8, AY = 4, key_state = 1: all keys set to 1.
  - AX = 8, AY = 5, 6, 7: MAGIC, RESET, PAUSE = key_state respectively.
  - Any other address: ignored, no error.
- Simultaneous SK rise and STB rise: the STB action is taken, the SK rise is discarded, and frame_err pulses.
- Read path (combinational): D = AND over r of (keys[r] | {COLS{A[8+r]}}). Rows ≥ ROWS contribute all ones.
- Reset: keys all 1, PAUSE/MAGIC/RESET = 0, counter = 0, shift register = 0, sync flops = 0, frame_err = 0, wdt_expired = 0.
- Special-key outputs are not cleared by the Z80 reset they cause; only rst_in, a command, or the watchdog clears them.

## Timing
- Pin edge first captured at clk edge n. The commit or shift takes effect at edge n+2, and D reflects a commit after edge n+2.
- MCU rules for SK and STB:
  - high and low pulse widths ≥ 2 clk;
  - DAT stable from 2 clk before each SK/STB rise until 2 clk after it.
- D, IORQGE and enable are combinational from A/M1/RD/IORQ and registered key state. They have no clk latency.
- frame_err is high for exactly the cycle after the rejected STB rise is detected.
- Reset asserted mid-frame aborts the frame. The first SK after release starts a fresh frame.

## Configuration
- KEYMATRIX_WDT_EN defined:
  - A counter clears on every valid commit (including heartbeat) and increments otherwise.
  - When it reaches WDT_CLKS-1, all keys are set to 1, PAUSE/MAGIC/RESET go to 0, and wdt_expired is set. The counter then holds.
  - wdt_expired clears on the next valid commit.
- KEYMATRIX_WDT_EN undefined: no counter exists, wdt_expired is constant 0, and key state persists indefinitely.

## Test plan
- Reset, then read A=#FEFE with M1=1, RD=0, IORQ=0 -> enable=1, D=5'b11111, PAUSE=MAGIC=RESET=0.
- Shift 7'b000_0000, STB with DAT=1 (CS press), then read A=#FEFE -> D=5'b11110. Read A=#7FFE -> D=5'b11111. STB with DAT=0 -> D=5'b11111 at STB capture +2 clk.
- Shift only 5 bits, then STB -> frame_err one pulse, D unchanged. Shift 7'b110_1000, STB DAT=1 -> RESET=1. STB DAT=0 -> RESET=0.
- Press Q (AX=2, AY=0) and P (AX=5, AY=0), then read A=#00FE -> D=5'b11110. Command AX=8, AY=4, DAT=1 -> D=5'b11111.
- SK and STB rising in the same clk -> frame_err pulse, shift register unchanged.
- With KEYMATRIX_WDT_EN, WDT_CLKS=100: press a key, then idle 100 clk -> keys released, wdt_expired=1. Heartbeat -> wdt_expired=0.
